branch_resolver: RTL

BRANCH_RESOLVER -- requirements
Module: branch_resolver

---
 rtl/common.sv | 27 ++
 rtl/sat_counter.sv | 32 +++
 rtl/branch_resolver.sv | 114 +++++++++++
 3 files changed

// File: rtl/common.sv
// Shared pipeline constants: opcodes, jump-type decode and resolve-source select.
package common;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  // Opcodes in the J-type encoding group (26-bit target field).
  localparam logic [5:0] J_TYPE_OP0 = OP_J;
  localparam logic [5:0] J_TYPE_OP1 = OP_JAL;

  // Instruction size in bytes; sequential next-PC step.
  localparam int unsigned INSN_BYTES = 4;

  // Where the resolved next-PC of the instruction in EX comes from.
  typedef enum logic [1:0] {
    PC4     = 2'd0,
    BTARGET = 2'd1,
    JTARGET = 2'd2
  } resolve_src_e;

  function automatic logic is_j_type(input logic [5:0] op);
    return (op == J_TYPE_OP0) || (op == J_TYPE_OP1);
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q, count_d;

  // Next count: step only while below the saturation value.
  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {WIDTH{1'b1}})) begin
      count_d = count_q + WIDTH'(1);
    end
  end

  // Count register, cleared asynchronously.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/branch_resolver.sv
// Tracks predicted next-PC through ID and EX, resolves the real next-PC in EX and
// flags mispredictions; keeps saturating branch and miss statistics.
module branch_resolver #(
  parameter int unsigned DWIDTH = 32,
  parameter int unsigned CWIDTH = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic [DWIDTH-1:0] if_pc,
  input  logic [DWIDTH-1:0] if_npc,
  input  logic              ex_jump,
  input  logic              ex_beq,
  input  logic              ex_zero,
  input  logic [DWIDTH-1:0] ex_btarget,
  input  logic [DWIDTH-1:0] ex_jtarget,
  output logic              control_hazard,
  output logic [DWIDTH-1:0] ex_pc,
  output logic [DWIDTH-1:0] ex_jpc,
  output logic [CWIDTH-1:0] branch_count,
  output logic [CWIDTH-1:0] miss_count
);

  import common::*;

  logic              id_valid_q, id_valid_d;
  logic [DWIDTH-1:0] id_pc_q, id_pc_d;
  logic [DWIDTH-1:0] id_pred_q, id_pred_d;
  logic              ex_valid_q, ex_valid_d;
  logic [DWIDTH-1:0] ex_pc_q, ex_pc_d;
  logic [DWIDTH-1:0] ex_pred_q, ex_pred_d;

  resolve_src_e      src;
  logic              branch_inc;

  // Resolve the real next-PC of the EX instruction; jump wins over a taken BEQ.
  always_comb begin
    src = PC4;
    if (ex_jump) begin
      src = JTARGET;
    end else if (ex_beq && ex_zero) begin
      src = BTARGET;
    end
    unique case (src)
      JTARGET: ex_jpc = ex_jtarget;
      BTARGET: ex_jpc = ex_btarget;
      default: ex_jpc = ex_pc_q + DWIDTH'(INSN_BYTES);
    endcase
  end

  // A mismatch also catches non-branches the predictor aliased as taken.
  assign control_hazard = ex_valid_q && (ex_jpc != ex_pred_q);
  assign ex_pc          = ex_pc_q;
  assign branch_inc     = ex_valid_q && (ex_jump || ex_beq);

  // Stage advance: stall holds ID and bubbles EX; a hazard flushes both stages.
  always_comb begin
    id_valid_d = id_valid_q;
    id_pc_d    = id_pc_q;
    id_pred_d  = id_pred_q;
    ex_valid_d = id_valid_q;
    ex_pc_d    = id_pc_q;
    ex_pred_d  = id_pred_q;
    if (!stall) begin
      id_valid_d = 1'b1;
      id_pc_d    = if_pc;
      id_pred_d  = if_npc;
    end else begin
      ex_valid_d = 1'b0;
    end
    if (control_hazard) begin
      id_valid_d = 1'b0;
      ex_valid_d = 1'b0;
    end
  end

  // Stage registers, cleared asynchronously so a pending flush is dropped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_valid_q <= 1'b0;
      id_pc_q    <= '0;
      id_pred_q  <= '0;
      ex_valid_q <= 1'b0;
      ex_pc_q    <= '0;
      ex_pred_q  <= '0;
    end else begin
      id_valid_q <= id_valid_d;
      id_pc_q    <= id_pc_d;
      id_pred_q  <= id_pred_d;
      ex_valid_q <= ex_valid_d;
      ex_pc_q    <= ex_pc_d;
      ex_pred_q  <= ex_pred_d;
    end
  end

  sat_counter #(
    .WIDTH(CWIDTH)
  ) u_branch_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (branch_inc),
    .count(branch_count)
  );

  sat_counter #(
    .WIDTH(CWIDTH)
  ) u_miss_cnt (
    .clk  (clk),
    .rst  (rst),
    .inc  (control_hazard),
    .count(miss_count)
  );

endmodule
